clk_div_cfg_ctrl: RTL

//  Owns the i_clk_en / i_div_ratio inputs of the CLK_DIV clock divider and changes them safely.
//  Two requesters (A = register-file config path, B = UART prescale path) ask for a new ratio.

---
 rtl/clk_div_cfg_pkg.sv | 21 ++
 rtl/clk_div_cfg_if.sv | 26 ++
 rtl/clk_div_cfg_ctrl_rr_arb2.sv | 36 +++
 rtl/clk_div_cfg_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/clk_div_cfg_pkg.sv
// Shared types and constants for the clock-divider configuration controller.
// State encoding, requester grant IDs and quiesce-count limits.
package clk_div_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_id_t;

    localparam int QUIESCE_MIN = 1;
    localparam int QUIESCE_MAX = 15;
    localparam int CNT_WD      = 4;

endpackage

// File: rtl/clk_div_cfg_if.sv
// Request/ack and divider-control bundle between requesters, the controller and CLK_DIV.
// The slave modport is the controller's view.
interface clk_div_cfg_if #(
    parameter int RATIO_WD = 8
);
    logic                i_en;
    logic                i_req_a;
    logic [RATIO_WD-1:0] i_ratio_a;
    logic                o_ack_a;
    logic                i_req_b;
    logic [RATIO_WD-1:0] i_ratio_b;
    logic                o_ack_b;
    logic                o_clk_en;
    logic [RATIO_WD-1:0] o_div_ratio;
    logic                o_busy;

    modport master (
        output i_en, i_req_a, i_ratio_a, i_req_b, i_ratio_b,
        input  o_ack_a, o_ack_b, o_clk_en, o_div_ratio, o_busy
    );

    modport slave (
        input  i_en, i_req_a, i_ratio_a, i_req_b, i_ratio_b,
        output o_ack_a, o_ack_b, o_clk_en, o_div_ratio, o_busy
    );
endinterface

// File: rtl/clk_div_cfg_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
// last_gnt is registered and, after a grant, names the requester currently being served.
module rr_arb2
    import clk_div_cfg_pkg::*;
(
    input  logic       i_ref_clk,
    input  logic       i_rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output gnt_id_t    last_gnt
);

    always_comb begin
        gnt = 2'b00;
        if (grant_en) begin
            if (req == 2'b11) begin
                gnt = (last_gnt == GNT_A) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset pointer at B so that A wins the first tie.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt <= GNT_B;
        end else if (gnt[1]) begin
            last_gnt <= GNT_B;
        end else if (gnt[0]) begin
            last_gnt <= GNT_A;
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Safely retunes CLK_DIV: gate the divider, load the new ratio, settle, re-enable, ack.
//   state  | meaning
//   IDLE   | o_clk_en follows i_en; arbitrate and capture the granted ratio
//   GATE   | divider gated for QUIESCE cycles; ratio loaded in the last one
//   SETTLE | divider still gated for QUIESCE cycles; o_clk_en <= i_en on exit
//   ACK    | one-cycle ack pulse to the granted requester
module clk_div_cfg_ctrl
    import clk_div_cfg_pkg::*;
#(
    parameter int RATIO_WD  = 8,
    parameter int QUIESCE   = 2,
    parameter int RST_RATIO = 1
)(
    input  logic          i_ref_clk,
    input  logic          i_rst_n,
    clk_div_cfg_if.slave  bus
);

    localparam int Q_EFF = (QUIESCE < QUIESCE_MIN) ? QUIESCE_MIN :
                           (QUIESCE > QUIESCE_MAX) ? QUIESCE_MAX : QUIESCE;
    localparam logic [CNT_WD-1:0]   CNT_LAST = CNT_WD'(Q_EFF - 1);
    localparam logic [RATIO_WD-1:0] RST_VAL  = RATIO_WD'(RST_RATIO);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_WD-1:0]   cnt_q;
    logic [RATIO_WD-1:0] ratio_cap_q;
    logic [RATIO_WD-1:0] div_ratio_q;
    logic                clk_en_q;
    logic [1:0]          gnt;
    gnt_id_t             last_gnt;
    logic                grant_en;
    logic                any_gnt;
    logic [RATIO_WD-1:0] sel_ratio;
    logic                ratio_match;
    logic                cnt_last;

    assign grant_en = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .i_ref_clk (i_ref_clk),
        .i_rst_n   (i_rst_n),
        .req       ({bus.i_req_b, bus.i_req_a}),
        .grant_en  (grant_en),
        .gnt       (gnt),
        .last_gnt  (last_gnt)
    );

    always_comb begin
        any_gnt     = |gnt;
        sel_ratio   = gnt[1] ? bus.i_ratio_b : bus.i_ratio_a;
        ratio_match = (sel_ratio == div_ratio_q);
        cnt_last    = (cnt_q == CNT_LAST);
        state_d     = state_q;
        case (state_q)
            ST_IDLE:   if (any_gnt)  state_d = ratio_match ? ST_ACK : ST_GATE;
            ST_GATE:   if (cnt_last) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_last) state_d = ST_ACK;
            ST_ACK:                  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q != ST_IDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ratio_cap_q <= RST_VAL;
            div_ratio_q <= RST_VAL;
            clk_en_q    <= 1'b0;
        end else begin
            if (grant_en && any_gnt) begin
                ratio_cap_q <= sel_ratio;
            end
            if (state_q == ST_GATE && cnt_last) begin
                div_ratio_q <= ratio_cap_q;
            end
            // A matching ratio skips the gate, so the enable is simply held.
            case (state_q)
                ST_IDLE: begin
                    if (any_gnt) begin
                        if (!ratio_match) clk_en_q <= 1'b0;
                    end else begin
                        clk_en_q <= bus.i_en;
                    end
                end
                ST_SETTLE: if (cnt_last) clk_en_q <= bus.i_en;
                default: ;
            endcase
        end
    end

    assign bus.o_clk_en    = clk_en_q;
    assign bus.o_div_ratio = div_ratio_q;
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_ack_a     = (state_q == ST_ACK) && (last_gnt == GNT_A);
    assign bus.o_ack_b     = (state_q == ST_ACK) && (last_gnt == GNT_B);

endmodule
